// File: rtl/mux_n_pipe.sv
// N-way registered select with valid/ready handshake; 2-entry skid keeps in_ready registered.
// Latency 1 cycle from accept to out_valid; full throughput while out_ready is held high.
// Backpressure: in_ready drops only when the skid entry fills. Optional sel_err via MUX_N_PIPE_SEL_CHECK_EN.
module mux_n_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        Select,
    input  logic [NUM_IN*WIDTH-1:0] I,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        Result
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    ,
    output logic                    sel_err
`endif
);

    logic             r_main_vld;
    logic             r_skid_vld;
    logic             r_in_rdy;
    logic [WIDTH-1:0] r_main_dat;
    logic [WIDTH-1:0] r_skid_dat;

    logic [WIDTH-1:0] w_word;
    logic             w_accept;
    logic             w_xfer;

    // Indices with no matching input (non-power-of-2 NUM_IN) fall through to zero.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (Select == SEL_W'(k)) begin
                w_word = I[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept = in_valid && r_in_rdy;
    assign w_xfer   = r_main_vld && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_main_dat <= '0;
            r_skid_dat <= '0;
        end else if (flush) begin
            // Result keeps its last value; only the valid state is dropped.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else if (!r_main_vld) begin
            if (w_accept) begin
                r_main_vld <= 1'b1;
                r_main_dat <= w_word;
            end
        end else if (!r_skid_vld) begin
            if (w_accept && w_xfer) begin
                r_main_dat <= w_word;
            end else if (w_xfer) begin
                r_main_vld <= 1'b0;
            end else if (w_accept) begin
                r_skid_vld <= 1'b1;
                r_skid_dat <= w_word;
                r_in_rdy   <= 1'b0;
            end
        end else if (w_xfer) begin
            r_main_dat <= r_skid_dat;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_main_vld;
    assign Result    = r_main_dat;

`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic r_sel_err;

    // Sticky until reset; accepts voided by flush do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (!flush && w_accept && (32'(Select) >= NUM_IN)) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-input instance for the handshake paths, a 3-input one for out-of-range select.
module tb_mux_n_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   sel;
    logic [127:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  res;

    logic         flush3;
    logic         in_valid3;
    logic         in_ready3;
    logic [1:0]   sel3;
    logic [95:0]  din3;
    logic         out_valid3;
    logic         out_ready3;
    logic [31:0]  res3;
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic         sel_err4;
    logic         sel_err3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Select(sel), .I(din), .out_valid(out_valid), .out_ready(out_ready), .Result(res)
`ifdef MUX_N_PIPE_SEL_CHECK_EN
        , .sel_err(sel_err4)
`endif
    );

    mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
        .Select(sel3), .I(din3), .out_valid(out_valid3), .out_ready(out_ready3), .Result(res3)
`ifdef MUX_N_PIPE_SEL_CHECK_EN
        , .sel_err(sel_err3)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled then too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", res); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        din       = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        sel       = 2'd2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        n_checks++; if (res !== 32'hCCCC_CCCC) begin n_fail++; $display("FAIL single_result got %h want cccccccc", res); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid); end
        n_checks++; if (res !== 32'hCCCC_CCCC) begin n_fail++; $display("FAIL single_hold got %h want cccccccc", res); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        din       = {32'h0, 32'h0, 32'h22, 32'h11};
        sel       = 2'd0;
        in_valid  = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_full1 got %b want 1", in_ready); end
        sel = 2'd1;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full2 got %b want 0", in_ready); end
        n_checks++; if (res !== 32'h11) begin n_fail++; $display("FAIL bp_result_first got %h want 00000011", res); end
        // Stimulus churn while nothing is accepted must not disturb held data.
        din = {4{32'hDEAD_BEEF}};
        sel = 2'd3;
        step();
        n_checks++; if (res !== 32'h11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %h/%b want 00000011/1", res, out_valid); end
        out_ready = 1'b1;
        step();
        n_checks++; if (res !== 32'h22 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second got %h/%b want 00000022/1", res, out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                din[k*32 +: 32] = 32'hA500_0000 + 32'(i * 16 + k);
            end
            sel      = 2'(i % 4);
            exp      = 32'hA500_0000 + 32'(i * 16 + i % 4);
            in_valid = 1'b1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            step();
            n_checks++; if (out_valid !== 1'b1 || res !== exp) begin n_fail++; $display("FAIL stream_word[%0d] got %h/%b want %h/1", i, res, out_valid, exp); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        din       = {32'h0, 32'h0, 32'h44, 32'h33};
        sel       = 2'd0;
        in_valid  = 1'b1;
        step();
        sel = 2'd1;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full2 got %b want 0", in_ready); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full2 got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_checks++; if (res !== 32'h33) begin n_fail++; $display("FAIL flush_keeps_result got %h want 00000033", res); end
        // Word offered during the flush cycle must vanish.
        din      = {32'h0, 32'h0, 32'h66, 32'h55};
        sel      = 2'd0;
        in_valid = 1'b1;
        step();
        sel   = 2'd1;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || res !== 32'h55) begin n_fail++; $display("FAIL flush_void got %h/%b want 00000055/0", res, out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost got %b want 0", out_valid); end
        din       = {32'h0, 32'h77, 32'h0, 32'h0};
        sel       = 2'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || res !== 32'h77) begin n_fail++; $display("FAIL flush_after got %h/%b want 00000077/1", res, out_valid); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        din       = {32'h0, 32'h0, 32'h0, 32'h88};
        sel       = 2'd0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || res !== 32'h88) begin n_fail++; $display("FAIL rstmid_pre got %h/%b want 00000088/1", res, out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || res !== 32'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid got %h/v%b/r%b want 00000000/v0/r1", res, out_valid, in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_sel_range();
        din3       = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        out_ready3 = 1'b1;
`ifdef MUX_N_PIPE_SEL_CHECK_EN
        n_checks++; if (sel_err3 !== 1'b0) begin n_fail++; $display("FAIL selerr_reset got %b want 0", sel_err3); end
`endif
        sel3      = 2'd1;
        in_valid3 = 1'b1;
        step();
        n_checks++; if (res3 !== 32'h2222_2222) begin n_fail++; $display("FAIL sel3_inrange got %h want 22222222", res3); end
`ifdef MUX_N_PIPE_SEL_CHECK_EN
        n_checks++; if (sel_err3 !== 1'b0) begin n_fail++; $display("FAIL selerr_inrange got %b want 0", sel_err3); end
`endif
        sel3 = 2'd3;
        step();
        in_valid3 = 1'b0;
        n_checks++; if (res3 !== 32'h0 || out_valid3 !== 1'b1) begin n_fail++; $display("FAIL sel3_oor got %h/%b want 00000000/1", res3, out_valid3); end
`ifdef MUX_N_PIPE_SEL_CHECK_EN
        n_checks++; if (sel_err3 !== 1'b1) begin n_fail++; $display("FAIL selerr_set got %b want 1", sel_err3); end
        flush3 = 1'b1;
        step();
        flush3 = 1'b0;
        n_checks++; if (sel_err3 !== 1'b1) begin n_fail++; $display("FAIL selerr_flush got %b want 1", sel_err3); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (sel_err3 !== 1'b0) begin n_fail++; $display("FAIL selerr_rst got %b want 0", sel_err3); end
`endif
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        sel        = '0;
        din        = '0;
        out_ready  = 1'b0;
        flush3     = 1'b0;
        in_valid3  = 1'b0;
        sel3       = '0;
        din3       = '0;
        out_ready3 = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_sel_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised successor to the 32-bit 2:1 select mux.
- N-way selector with a registered output stage and a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered and gives full throughput.
- Used at pipeline-stage boundaries: operand/forwarding select into EX, writeback select into WB. Supports stall via backpressure and flush.

Parameters:
- WIDTH, 32, data width of each input and of Result.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; drops all held data.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  block can accept; registered.
- Select  input  SEL_W  input index, sampled on acceptance.
- I  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  Result holds a valid word.
- out_ready  input  1  downstream accepts Result.
- Result  output  WIDTH  selected, registered data.
- sel_err  output  1  sticky out-of-range select flag; present only with the macro.

Behaviour:
- Reset and interface: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, Result=0, in_ready=1, skid empty, sel_err=0.
- Accept occurs when in_valid && in_ready at a rising edge. Transfer occurs when out_valid && out_ready.
- Captured word = I[Select] at the accept edge.
- Out-of-range Select (Select >= NUM_IN, possible only when NUM_IN is not a power of 2) captures all-zero.
- Latency: accept at edge n gives out_valid=1 with data after edge n when the main register is free; 1 cycle.
- State is {main_valid, skid_valid}:
  - EMPTY (0,0):
    - accept -> FULL1, main<=word.
  - FULL1 (1,0):
    - accept with transfer -> FULL1, main<=new word.
    - transfer only -> EMPTY.
    - accept without transfer -> FULL2, skid<=word.
    - neither -> hold.
  - FULL2 (1,1): in_ready=0, so no accept.
    - transfer -> FULL1, main<=skid, skid cleared.
    - no transfer -> hold.
- in_ready = !skid_valid, driven from a register. It deasserts the cycle after entry to FULL2 and reasserts the cycle after leaving it.
- Throughput: one word per cycle when out_ready is held high.
- Ordering: strict FIFO; the skid word always follows the main word.
- Result is stable while out_valid=1 && out_ready=0.
- Result keeps its last value when out_valid=0.
- Priority: rst > flush > handshake.
- flush forces EMPTY next cycle, and in_ready=1 next cycle.
- Any accept or transfer in the flush cycle is void: the word is discarded and the downstream must ignore it.
- Result is not cleared by flush.
- Reset mid-operation discards everything and is equivalent to power-up.
- Select and I changes while not accepting have no effect.

Optional Feature:
- Macro: MUX_N_PIPE_SEL_CHECK_EN.
- Defined:
  - sel_err port exists.
  - sel_err is set on any accept with Select >= NUM_IN.
  - Sticky until rst; flush does not clear it.
  - The word is still captured as all-zero.
- Undefined:
  - No sel_err port and no checking logic.
  - Out-of-range accepts still capture all-zero silently.

Test Plan:
- Reset then single word: NUM_IN=4, I={D,C,B,A}=…, Select=2, in_valid=1 one cycle, out_ready=1 -> out_valid=1 one cycle after accept, Result=0xCCCC_CCCC; then out_valid=0.
- Backpressure: out_ready=0, send 0x11 (sel0) and 0x22 (sel1) on consecutive cycles -> in_ready=0 after the 2nd accept. Result holds 0x11. Raise out_ready -> 0x11 then 0x22 in order, in_ready=1 again.
- Streaming: out_ready=1, 8 back-to-back accepts cycling Select 0..3 -> 8 outputs on 8 consecutive cycles with matching data; in_ready never drops.
- Flush in FULL2: fill both entries, assert flush one cycle -> out_valid=0 and in_ready=1 next cycle; a word accepted in the flush cycle never appears.
- Reset mid-stream: rst during FULL1 with out_ready=0 -> out_valid=0, Result=0, in_ready=1 next cycle.
- NUM_IN=3 with the macro: accept with Select=3 -> Result=0, sel_err=1. Remains 1 after flush; 0 after rst. Without the macro: Result=0, no port.
